axi4lite_bram: RTL and testbench

- AXI4-lite responder backed by an inferred single-clock block RAM.
- Serves as on-chip instruction/data memory next to axi4lite_flash on the system bus.
- Answers reads from initiators such as ifetch; accepts byte-masked writes.
- One outstanding transaction per direction; read and write paths operate independently.

---
 rtl/axi4lite_bram_if.sv | 33 +++
 rtl/axi4lite_bram.sv | 139 +++++++++++++
 tb/tb_axi4lite_bram.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_bram_if.sv
// AXI4-lite bundle between a system-bus initiator and axi4lite_bram.
interface axi4lite_bram_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) ();
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_bram.sv
// AXI4-lite responder over an inferred single-clock read-first block RAM.
// Optional macro AXI4LITE_BRAM_WRITE_PROTECT_EN: the lowest PROTECT_WORDS words become read-only.
module axi4lite_bram #(
  parameter int unsigned ADDR_WIDTH    = 24,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter              INIT_FILE     = "",
  parameter int unsigned PROTECT_WORDS = 256
) (
  input logic            aclk,
  input logic            aresetn,
  axi4lite_bram_if.slave bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AXI4LITE_BRAM_WRITE_PROTECT_EN
  localparam bit PROTECT_ON = 1'b1;
`else
  localparam bit PROTECT_ON = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (IDX_W + OFF_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[IDX_W+OFF_W-1:OFF_W];
  endfunction

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  r_state_t              r_state, r_state_nx;
  logic                  arready_nx, rvalid_nx, rd_load, ar_hs;
  logic [ADDR_WIDTH-1:0] araddr_q;

  logic                  aw_full, w_full, aw_full_nx, w_full_nx;
  logic                  bvalid_nx, wr_fire, wr_ok;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  assign ar_hs = bus.arvalid && bus.arready;

  // Read path: RAM is read on the cycle after accept from the latched address.
  always_comb begin
    r_state_nx = r_state;
    rvalid_nx  = bus.rvalid;
    rd_load    = 1'b0;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_nx = R_RESP;
      R_RESP: begin
        if (!bus.rvalid) begin
          rd_load   = 1'b1;
          rvalid_nx = 1'b1;
        end else if (bus.rready) begin
          rvalid_nx  = 1'b0;
          r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
    arready_nx = (r_state_nx == R_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rresp   <= RESP_OKAY;
    end else begin
      r_state     <= r_state_nx;
      bus.arready <= arready_nx;
      bus.rvalid  <= rvalid_nx;
      if (rd_load) bus.rresp <= in_range(araddr_q) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Write path: AW and W park independently; the RAM write fires once both are held.
  always_comb begin
    aw_full_nx = aw_full;
    w_full_nx  = w_full;
    bvalid_nx  = bus.bvalid;
    wr_fire    = 1'b0;
    if (bus.awvalid && bus.awready) aw_full_nx = 1'b1;
    if (bus.wvalid && bus.wready)   w_full_nx  = 1'b1;
    if (aw_full && w_full && !bus.bvalid) begin
      wr_fire   = 1'b1;
      bvalid_nx = 1'b1;
    end else if (bus.bvalid && bus.bready) begin
      bvalid_nx  = 1'b0;
      aw_full_nx = 1'b0;
      w_full_nx  = 1'b0;
    end
  end

  assign wr_ok = in_range(awaddr_q) &&
                 !(PROTECT_ON && (32'(word_idx(awaddr_q)) < PROTECT_WORDS));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
    end else begin
      aw_full     <= aw_full_nx;
      w_full      <= w_full_nx;
      bus.awready <= !aw_full_nx;
      bus.wready  <= !w_full_nx;
      bus.bvalid  <= bvalid_nx;
      if (wr_fire) bus.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs) araddr_q <= bus.araddr;
    if (bus.awvalid && bus.awready) awaddr_q <= bus.awaddr;
    if (bus.wvalid && bus.wready) begin
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
  end

  // Memory is never reset; read and write on the same edge return the old word.
  always_ff @(posedge aclk) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < STRB_W; i++)
        if (wstrb_q[i]) mem[word_idx(awaddr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
    end
    if (rd_load) bus.rdata <= in_range(araddr_q) ? mem[word_idx(araddr_q)] : '0;
  end
endmodule

// File: tb/tb_axi4lite_bram.sv
// Randomized self-checking bench for axi4lite_bram against a word/byte memory model.
module tb_axi4lite_bram;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int PROT  = 256;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi4lite_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4lite_bram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
    .INIT_FILE(""), .PROTECT_WORDS(PROT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );

  logic [31:0] mdl   [DEPTH];
  logic [3:0]  known [DEPTH];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_in_range(input logic [23:0] a);
    return a < 24'(DEPTH * 4);
  endfunction

  function automatic bit mdl_protected(input int idx);
`ifdef AXI4LITE_BRAM_WRITE_PROTECT_EN
    return idx < PROT;
`else
    return idx < 0;
`endif
  endfunction

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, output logic [1:0] resp);
    int c, aw_start, w_start;
    bit aw_d, w_d;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    c = 0; aw_d = 0; w_d = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_d && w_d) && c < 40) begin
      @(negedge aclk);
      if (aw_d) check_eq("awready_held_low", 64'(bus.awready), 64'd0);
      if (w_d)  check_eq("wready_held_low", 64'(bus.wready), 64'd0);
      bus.awvalid = !aw_d && (c >= aw_start);
      bus.wvalid  = !w_d && (c >= w_start);
      if (bus.awvalid && bus.awready) aw_d = 1;
      if (bus.wvalid && bus.wready)   w_d  = 1;
      c++;
    end
    check_eq("wr_accept_timeout", 64'(aw_d && w_d), 64'd1);
    @(negedge aclk);
    bus.awvalid = 0; bus.wvalid = 0;
    check_eq("bvalid_early", 64'(bus.bvalid), 64'd0);
    @(negedge aclk);
    check_eq("bvalid_latency", 64'(bus.bvalid), 64'd1);
    resp = bus.bresp;
    bus.bready = 1;
    @(negedge aclk);
    bus.bready = 0;
    check_eq("bvalid_cleared", 64'(bus.bvalid), 64'd0);
    check_eq("awready_restored", 64'(bus.awready), 64'd1);
    check_eq("wready_restored", 64'(bus.wready), 64'd1);
  endtask

  task automatic do_read(input logic [23:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int c;
    logic [31:0] d0;
    c = 0;
    @(negedge aclk);
    bus.araddr = addr; bus.arvalid = 1;
    while (!bus.arready && c < 20) begin
      @(negedge aclk);
      c++;
    end
    check_eq("rd_accept_timeout", 64'(c < 20), 64'd1);
    @(negedge aclk);
    bus.arvalid = 0;
    check_eq("rvalid_early", 64'(bus.rvalid), 64'd0);
    check_eq("arready_dropped", 64'(bus.arready), 64'd0);
    @(negedge aclk);
    check_eq("rvalid_latency", 64'(bus.rvalid), 64'd1);
    d0 = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check_eq("rvalid_stable", 64'(bus.rvalid), 64'd1);
      check_eq("rdata_stable", 64'(bus.rdata), 64'(d0));
      check_eq("arready_low_in_resp", 64'(bus.arready), 64'd0);
    end
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1;
    @(negedge aclk);
    bus.rready = 0;
    check_eq("rvalid_cleared", 64'(bus.rvalid), 64'd0);
    check_eq("arready_restored", 64'(bus.arready), 64'd1);
  endtask

  task automatic write_check(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input string tag);
    logic [1:0] r, er;
    int idx;
    do_write(addr, data, strb, w_lead, r);
    idx = int'(addr) / 4;
    if (mdl_in_range(addr) && !mdl_protected(idx)) begin
      er = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) begin
          mdl[idx][8*b +: 8] = data[8*b +: 8];
          known[idx][b] = 1'b1;
        end
    end else begin
      er = 2'b10;
    end
    check_eq({tag, "_bresp"}, 64'(r), 64'(er));
  endtask

  task automatic read_check(input logic [23:0] addr, input int hold, input string tag);
    logic [31:0] d, m;
    logic [1:0]  r;
    int idx;
    do_read(addr, hold, d, r);
    if (mdl_in_range(addr)) begin
      idx = int'(addr) / 4;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{known[idx][b]}};
      check_eq({tag, "_rresp"}, 64'(r), 64'd0);
      if (m != 0) check_eq({tag, "_rdata"}, 64'(d & m), 64'(mdl[idx] & m));
    end else begin
      check_eq({tag, "_rresp"}, 64'(r), 64'h2);
      check_eq({tag, "_rdata"}, 64'(d), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, d_before;
    logic [1:0]  r;
    logic [9:0]  pool [16];
    logic [23:0] a;
    int c;

    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = '0;
      mdl[i]   = '0;
    end

    aresetn = 0;
    repeat (3) @(negedge aclk);
    check_eq("rst_arready", 64'(bus.arready), 64'd0);
    check_eq("rst_awready", 64'(bus.awready), 64'd0);
    check_eq("rst_wready", 64'(bus.wready), 64'd0);
    check_eq("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("rst_rresp", 64'(bus.rresp), 64'd0);
    check_eq("rst_bresp", 64'(bus.bresp), 64'd0);
    aresetn = 1;
    @(negedge aclk);
    check_eq("post_rst_arready", 64'(bus.arready), 64'd1);
    check_eq("post_rst_awready", 64'(bus.awready), 64'd1);
    check_eq("post_rst_wready", 64'(bus.wready), 64'd1);

    // Directed: masked write with W leading AW by three cycles
    write_check(24'h400, 32'hAABBCCDD, 4'hF, 0, "wr_full");
    write_check(24'h400, 32'h11223344, 4'b0101, 3, "wr_masked");
    do_read(24'h400, 0, d, r);
    check_eq("rd_masked_data", 64'(d), 64'hAA22CC44);
    check_eq("rd_masked_resp", 64'(r), 64'd0);
    do_read(24'h403, 0, d, r);
    check_eq("rd_unaligned_data", 64'(d), 64'hAA22CC44);

    // Out of range: reads return zero, writes to an aliasing address leave memory alone
    do_read(24'h1000, 0, d, r);
    check_eq("rd_oor_resp", 64'(r), 64'h2);
    check_eq("rd_oor_data", 64'(d), 64'd0);
    write_check(24'h1000, 32'h0BAD0BAD, 4'hF, -2, "wr_oor0");
    write_check(24'h1400, 32'h0BAD0BAD, 4'hF, 0, "wr_oor_alias");
    do_read(24'h400, 0, d, r);
    check_eq("oor_no_alias_write", 64'(d), 64'hAA22CC44);

    write_check(24'h400, 32'hFFFFFFFF, 4'h0, 1, "wr_nostrb");
    do_read(24'h400, 5, d, r);
    check_eq("nostrb_unchanged", 64'(d), 64'hAA22CC44);

    // Reset pulsed while a response is pending
    @(negedge aclk);
    bus.araddr = 24'h400; bus.arvalid = 1;
    c = 0;
    while (!bus.arready && c < 20) begin
      @(negedge aclk);
      c++;
    end
    @(negedge aclk);
    bus.arvalid = 0;
    @(negedge aclk);
    check_eq("rvalid_before_rst", 64'(bus.rvalid), 64'd1);
    #2 aresetn = 0;
    #1;
    check_eq("rvalid_async_rst", 64'(bus.rvalid), 64'd0);
    check_eq("arready_async_rst", 64'(bus.arready), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    check_eq("arready_at_release", 64'(bus.arready), 64'd0);
    @(negedge aclk);
    check_eq("arready_after_rerst", 64'(bus.arready), 64'd1);
    do_read(24'h400, 0, d, r);
    check_eq("rd_after_rerst", 64'(d), 64'hAA22CC44);

`ifdef AXI4LITE_BRAM_WRITE_PROTECT_EN
    do_read(24'h3FC, 0, d_before, r);
    do_write(24'h3FC, 32'h5, 4'hF, 0, r);
    check_eq("prot_bresp", 64'(r), 64'h2);
    do_read(24'h3FC, 0, d, r);
    check_eq("prot_unchanged", 64'(d), 64'(d_before));
    write_check(24'h400, 32'h5, 4'hF, 0, "prot_open");
    do_read(24'h400, 0, d, r);
    check_eq("prot_open_data", 64'(d), 64'h5);
`endif

    // Randomized traffic over a small pool of words spread across the array
    for (int i = 0; i < 16; i++) pool[i] = 10'((i * 67 + 3) % DEPTH);
    for (int i = 0; i < 16; i++)
      write_check(24'({pool[i], 2'b00}), $urandom, 4'hF, int'($urandom_range(0, 6)) - 3, "rnd_init");
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) a = 24'($urandom_range(DEPTH * 4, 24'hFFFFFF));
      else a = 24'({pool[$urandom_range(0, 15)], 2'($urandom_range(0, 3))});
      if ($urandom_range(0, 1) == 1)
        write_check(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3, "rnd_wr");
      else
        read_check(a, int'($urandom_range(0, 2)), "rnd_rd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
